// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field layout, rounding modes, flag bits,
// integer saturation values and the float-to-int converter state encoding.
package fpu_pkg;

  localparam int unsigned BIAS   = 127;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = FRAC_W + 1;

  typedef enum logic [2:0] {
    RmRne = 3'b000,
    RmRtz = 3'b001,
    RmRdn = 3'b010,
    RmRup = 3'b011,
    RmRmm = 3'b100
  } rm_e;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StRound,
    StResp
  } state_e;

endpackage

// File: rtl/fcvt_w_s_if.sv
// Operand/result handshake bundle for the float-to-int converter.
interface fcvt_w_s_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [2:0]  rm;
  logic        is_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [4:0]  fflags;

  modport master (
    output in_valid, rs1, rm, is_unsigned, out_ready,
    input  in_ready, out_valid, out, fflags
  );

  modport slave (
    input  in_valid, rs1, rm, is_unsigned, out_ready,
    output in_ready, out_valid, out, fflags
  );
endinterface

// File: rtl/fp_unpack.sv
// Combinational single-precision field split and classification.
module fp_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [SIG_W-1:0]  sig_o,
  output logic              is_zero_o,
  output logic              is_sub_o,
  output logic              is_inf_o,
  output logic              is_nan_o
);
  logic [FRAC_W-1:0] frac;
  logic              exp_zero;
  logic              exp_ones;

  always_comb begin
    sign_o    = op_i[31];
    exp_o     = op_i[30:23];
    frac      = op_i[22:0];
    exp_zero  = (exp_o == '0);
    exp_ones  = (exp_o == '1);
    sig_o     = {!exp_zero, frac};
    is_zero_o = exp_zero && (frac == '0);
    is_sub_o  = exp_zero && (frac != '0);
    is_inf_o  = exp_ones && (frac == '0);
    is_nan_o  = exp_ones && (frac != '0);
  end
endmodule

// File: rtl/fcvt_w_s.sv
// FCVT.W.S / FCVT.WU.S: single-precision to 32-bit integer, one op in flight,
// align -> round -> respond, with saturation and NV/NX flags.
module fcvt_w_s
  import fpu_pkg::*;
#(
  parameter int unsigned ALIGN_PIPE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  fcvt_w_s_if.slave   io
);
  state_e      state_q, state_d;
  logic [31:0] rs1_q, rs1_d;
  logic [2:0]  rm_q, rm_d;
  logic        uns_q, uns_d;
  logic [63:0] v_q, v_d;
  logic        sticky_q, sticky_d, ovf_q, ovf_d, nan_q, nan_d;
  logic [31:0] out_q, out_d;
  logic [4:0]  fflags_q, fflags_d;
  logic        out_valid_q, out_valid_d;

  logic             sign, is_zero, is_sub, is_inf, is_nan;
  logic [EXP_W-1:0] exp;
  logic [SIG_W-1:0] sig;

  fp_unpack u_unpack (
    .op_i      (rs1_q),
    .sign_o    (sign),
    .exp_o     (exp),
    .sig_o     (sig),
    .is_zero_o (is_zero),
    .is_sub_o  (is_sub),
    .is_inf_o  (is_inf),
    .is_nan_o  (is_nan)
  );

  // Align: V = sig * 2^(E+9) as Q32.32, with bits below 2^-32 folded into sticky.
  logic signed [9:0] exp_eff, shamt;
  logic [9:0]        rshamt;
  logic [47:0]       rsh;
  logic [63:0]       v_a;
  logic              sticky_a, ovf_a;

  always_comb begin
    exp_eff  = (is_sub || is_zero) ? -10'sd126
                                   : $signed({2'b00, exp}) - $signed(10'(BIAS));
    shamt    = exp_eff + 10'sd9;
    rshamt   = -shamt;
    rsh      = '0;
    v_a      = '0;
    sticky_a = 1'b0;
    ovf_a    = is_inf || (exp_eff >= 10'sd32);
    if (!shamt[9]) begin
      if (!ovf_a) v_a = {40'b0, sig} << shamt[5:0];
    end else if (shamt < -10'sd24) begin
      sticky_a = !is_zero;
    end else begin
      rsh      = {sig, 24'b0} >> rshamt;
      v_a      = {40'b0, rsh[47:24]};
      sticky_a = |rsh[23:0];
    end
  end

  // Round consumes the align registers, or the align logic directly when unpiped.
  logic [63:0] v_r;
  logic        sticky_r, ovf_r, nan_r;
  logic [31:0] int_p;
  logic        rbit, tbit, inc, legal;
  logic [32:0] mag;
  logic [31:0] res;
  logic [4:0]  flg;

  always_comb begin
    v_r      = (ALIGN_PIPE != 0) ? v_q : v_a;
    sticky_r = (ALIGN_PIPE != 0) ? sticky_q : sticky_a;
    ovf_r    = (ALIGN_PIPE != 0) ? ovf_q : ovf_a;
    nan_r    = (ALIGN_PIPE != 0) ? nan_q : is_nan;
    int_p    = v_r[63:32];
    rbit     = v_r[31];
    tbit     = (|v_r[30:0]) || sticky_r;
    case (rm_e'(rm_q))
      RmRtz:   inc = 1'b0;
      RmRdn:   inc = sign && (rbit || tbit);
      RmRup:   inc = !sign && (rbit || tbit);
      RmRmm:   inc = rbit;
      default: inc = rbit && (tbit || int_p[0]);
    endcase
    mag = {1'b0, int_p} + {32'b0, inc};
    if (uns_q) legal = (!sign && !mag[32]) || (mag == '0);
    else       legal = sign ? (mag <= 33'h0_8000_0000) : (mag <= 33'h0_7FFF_FFFF);
    flg = '0;
    if (nan_r) begin
      res          = uns_q ? UINT_MAX : INT_MAX;
      flg[FLAG_NV] = 1'b1;
    end else if (ovf_r || !legal) begin
      if (uns_q) res = sign ? 32'h0 : UINT_MAX;
      else       res = sign ? INT_MIN : INT_MAX;
      flg[FLAG_NV] = 1'b1;
    end else begin
      res          = (!uns_q && sign) ? -mag[31:0] : mag[31:0];
      flg[FLAG_NX] = rbit || tbit;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs1_q       <= '0;
      rm_q        <= '0;
      uns_q       <= 1'b0;
      v_q         <= '0;
      sticky_q    <= 1'b0;
      ovf_q       <= 1'b0;
      nan_q       <= 1'b0;
      out_q       <= '0;
      fflags_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rs1_q       <= rs1_d;
      rm_q        <= rm_d;
      uns_q       <= uns_d;
      v_q         <= v_d;
      sticky_q    <= sticky_d;
      ovf_q       <= ovf_d;
      nan_q       <= nan_d;
      out_q       <= out_d;
      fflags_q    <= fflags_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rm_d        = rm_q;
    uns_d       = uns_q;
    v_d         = v_q;
    sticky_d    = sticky_q;
    ovf_d       = ovf_q;
    nan_d       = nan_q;
    out_d       = out_q;
    fflags_d    = fflags_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (io.in_valid) begin
          rs1_d   = io.rs1;
          rm_d    = io.rm;
          uns_d   = io.is_unsigned;
          state_d = StAlign;
        end
      end
      StAlign: begin
        v_d      = v_a;
        sticky_d = sticky_a;
        ovf_d    = ovf_a;
        nan_d    = is_nan;
        if (ALIGN_PIPE != 0) begin
          state_d = StRound;
        end else begin
          out_d    = res;
          fflags_d = flg;
          state_d  = StResp;
        end
      end
      StRound: begin
        out_d    = res;
        fflags_d = flg;
        state_d  = StResp;
      end
      StResp: begin
        // Result registers settle for one cycle before valid is raised.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    io.in_ready  = (state_q == StIdle);
    io.out_valid = out_valid_q;
    io.out       = out_q;
    io.fflags    = fflags_q;
  end
endmodule

// File: tb/tb_fcvt_w_s.sv
// Directed bench for fcvt_w_s: scoreboard of expected results, checked on out_valid.
module tb_fcvt_w_s;
  localparam logic [4:0] NV = 5'b10000;
  localparam logic [4:0] NX = 5'b00001;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fcvt_w_s_if bus ();

  fcvt_w_s #(.ALIGN_PIPE(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic drive(input logic [31:0] op, input logic [2:0] m, input logic u);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.rs1         = op;
    bus.rm          = m;
    bus.is_unsigned = u;
    @(posedge clk);
    #1;
    // Garbage after acceptance must not disturb the op in flight.
    bus.in_valid    = 1'b0;
    bus.rs1         = $urandom;
    bus.rm          = 3'($urandom_range(0, 7));
    bus.is_unsigned = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input string tag, input logic [31:0] op, input logic [2:0] m,
                     input logic u, input logic [31:0] want, input logic [4:0] wflg,
                     input int want_lat, input int hold);
    int          lat;
    logic        seen;
    exp_t        e;
    logic [31:0] o_ref;
    logic [4:0]  f_ref;
    sb.push_back('{tag, want, wflg});
    bus.out_ready = (hold == 0);
    drive(op, m, u);
    lat  = 0;
    seen = 1'b0;
    while (lat < 20 && !seen) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = bus.out_valid;
    end
    e = sb.pop_front();
    if (!seen) begin
      check({e.tag, "_timeout"}, 32'd0, 32'd1);
      bus.out_ready = 1'b1;
      return;
    end
    if (want_lat >= 0) check({e.tag, "_latency"}, lat, want_lat);
    check({e.tag, "_out"}, bus.out, e.res);
    check({e.tag, "_flags"}, {27'b0, bus.fflags}, {27'b0, e.flg});
    if (hold > 0) begin
      o_ref = e.res;
      f_ref = e.flg;
      repeat (hold) begin
        @(negedge clk);
        check({e.tag, "_hold_out"}, bus.out, o_ref);
        check({e.tag, "_hold_flags"}, {27'b0, bus.fflags}, {27'b0, f_ref});
        check({e.tag, "_hold_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
        check({e.tag, "_hold_valid"}, {31'b0, bus.out_valid}, 32'd1);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({e.tag, "_valid_drop"}, {31'b0, bus.out_valid}, 32'd0);
    check({e.tag, "_idle_out"}, bus.out, e.res);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.rs1         = '0;
    bus.rm          = '0;
    bus.is_unsigned = 1'b0;
    #1;
    check("rst_out", bus.out, 32'd0);
    check("rst_flags", {27'b0, bus.fflags}, 32'd0);
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    run("p3p5_rne",  32'h4060_0000, 3'b000, 1'b0, 32'h0000_0004, NX, 3, 0);
    run("p3p5_rtz",  32'h4060_0000, 3'b001, 1'b0, 32'h0000_0003, NX, 3, 0);
    run("p3p5_rm7",  32'h4060_0000, 3'b111, 1'b0, 32'h0000_0004, NX, -1, 0);
    run("m2p5_rne",  32'hC020_0000, 3'b000, 1'b0, 32'hFFFF_FFFE, NX, -1, 0);
    run("m2p5_rmm",  32'hC020_0000, 3'b100, 1'b0, 32'hFFFF_FFFD, NX, -1, 0);
    run("m2p5_rup",  32'hC020_0000, 3'b011, 1'b0, 32'hFFFF_FFFE, NX, -1, 0);
    run("m2p5_rdn",  32'hC020_0000, 3'b010, 1'b0, 32'hFFFF_FFFD, NX, -1, 0);
    run("m2p31_s",   32'hCF00_0000, 3'b000, 1'b0, 32'h8000_0000, 5'b0, -1, 0);
    run("p2p31_s",   32'h4F00_0000, 3'b000, 1'b0, 32'h7FFF_FFFF, NV, -1, 0);
    run("p2p31_u",   32'h4F00_0000, 3'b000, 1'b1, 32'h8000_0000, 5'b0, -1, 0);
    run("nan_s",     32'h7FC0_0000, 3'b000, 1'b0, 32'h7FFF_FFFF, NV, -1, 0);
    run("nan_u",     32'h7FC0_0000, 3'b000, 1'b1, 32'hFFFF_FFFF, NV, -1, 0);
    run("ninf_s",    32'hFF80_0000, 3'b000, 1'b0, 32'h8000_0000, NV, -1, 0);
    run("ninf_u",    32'hFF80_0000, 3'b000, 1'b1, 32'h0000_0000, NV, -1, 0);
    run("sub_rup",   32'h0000_0001, 3'b011, 1'b0, 32'h0000_0001, NX, -1, 0);
    run("m0p25_u",   32'hBE80_0000, 3'b000, 1'b1, 32'h0000_0000, NX, -1, 0);
    run("m1_u",      32'hBF80_0000, 3'b000, 1'b1, 32'h0000_0000, NV, -1, 0);
    run("nzero_s",   32'h8000_0000, 3'b000, 1'b0, 32'h0000_0000, 5'b0, -1, 0);
    run("p123_hold", 32'h42F6_0000, 3'b000, 1'b0, 32'h0000_007B, 5'b0, 3, 5);

    // Reset while the op sits in ROUND: nothing may emerge.
    drive(32'h4060_0000, 3'b000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_mid_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'b0, bus.in_ready}, 32'd1);
    #2;
    resetn = 1'b1;
    run("after_rst", 32'h3FC0_0000, 3'b000, 1'b0, 32'h0000_0002, NX, 3, 0);

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
